hdlc_rx_drain: RTL and testbench

Register-bus controller that sequences the HDLC core's receive side. It polls the Rx status register and, when a frame is ready, reads the frame length and then every byte of the Rx buffer. The bytes are delivered on a valid/ready byte stream. The block sits between the HDLC core's 3-bit address/data register port (as bus master) and a downstream byte consumer, and is the only master of that port while enabled.

---
 rtl/hdlc_rx_drain.sv | 207 ++++++++++++++++++++
 tb/tb_hdlc_rx_drain.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_drain.sv
// Receive-side sequencer for the HDLC core: polls Rx_SC and drains each ready frame
// (length, then every buffer byte) onto a valid/ready byte stream.
//
// state    | meaning
// IDLE     | waiting for Enable before the next poll
// POLL     | read strobe on Rx_SC
// WAIT_SC  | Rx_SC data returns; choose drop, length read or gap
// RD_LEN   | read strobe on Rx_Len
// WAIT_LEN | Rx_Len data returns; range check
// RD_BUF   | read strobe on Rx_Buff
// WAIT_BUF | buffer byte returns and is captured
// PUSH     | byte offered downstream until accepted
// DROP     | write Rx_Drop to Rx_SC, pulse FrameDrop
// DONE     | pulse FrameDone
// GAP      | idle spacing between polls
module hdlc_rx_drain #(
    parameter int POLL_GAP = 4,
    parameter int MAX_LEN  = 126
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Enable,
    output logic [2:0] Address,
    output logic       WriteEnable,
    output logic       ReadEnable,
    output logic [7:0] DataIn,
    input  logic [7:0] DataOut,
    output logic [7:0] Byte,
    output logic       ByteValid,
    output logic       ByteLast,
    input  logic       ByteReady,
    output logic       FrameDone,
    output logic       FrameDrop,
    output logic [2:0] DropCode,
    output logic       Busy
);

    typedef enum logic [3:0] {
        IDLE, POLL, WAIT_SC, RD_LEN, WAIT_LEN, RD_BUF, WAIT_BUF, PUSH, DROP, DONE, GAP
    } state_t;

    localparam logic [2:0] ADDR_SC   = 3'd2;
    localparam logic [2:0] ADDR_BUFF = 3'd3;
    localparam logic [2:0] ADDR_LEN  = 3'd4;
    localparam logic [7:0] GAP_LOAD  = 8'(POLL_GAP - 1);
    localparam logic [7:0] LEN_MAX   = 8'(MAX_LEN);

    state_t     state_q, state_d;
    logic [7:0] sc_q, sc_d;
    logic [7:0] len_q, len_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] gap_q, gap_d;
    logic [2:0] address_q, address_d;
    logic       we_q, we_d, re_q, re_d;
    logic [7:0] data_in_q, data_in_d;
    logic [7:0] byte_q, byte_d;
    logic       valid_q, valid_d, last_q, last_d;
    logic       done_q, done_d, drop_q, drop_d;
    logic [2:0] code_q, code_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d   = state_q;
        sc_d      = sc_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        address_d = address_q;
        we_d      = 1'b0;
        re_d      = 1'b0;
        data_in_d = 8'h00;
        byte_d    = byte_q;
        valid_d   = valid_q;
        last_d    = last_q;
        done_d    = 1'b0;
        drop_d    = 1'b0;
        code_d    = code_q;

        // Outputs are registered, so each strobe is set on the transition into its state.
        case (state_q)
            IDLE: if (Enable) begin
                state_d   = POLL;
                re_d      = 1'b1;
                address_d = ADDR_SC;
            end
            POLL: state_d = WAIT_SC;
            WAIT_SC: begin
                sc_d = DataOut;
                if (DataOut[3] || DataOut[2]) begin
                    state_d   = DROP;
                    we_d      = 1'b1;
                    address_d = ADDR_SC;
                    data_in_d = 8'h02;
                    drop_d    = 1'b1;
                    code_d    = 3'b010;
                end else if (DataOut[0]) begin
                    state_d   = RD_LEN;
                    re_d      = 1'b1;
                    address_d = ADDR_LEN;
                end else begin
                    state_d = GAP;
                    gap_d   = GAP_LOAD;
                end
            end
            RD_LEN: state_d = WAIT_LEN;
            WAIT_LEN: begin
                len_d = DataOut;
                cnt_d = 8'd0;
                if (DataOut == 8'd0 || DataOut > LEN_MAX) begin
                    state_d   = DROP;
                    we_d      = 1'b1;
                    address_d = ADDR_SC;
                    data_in_d = 8'h02;
                    drop_d    = 1'b1;
                    code_d    = 3'b001;
                end else begin
                    state_d   = RD_BUF;
                    re_d      = 1'b1;
                    address_d = ADDR_BUFF;
                end
            end
            RD_BUF: state_d = WAIT_BUF;
            WAIT_BUF: begin
                state_d = PUSH;
                byte_d  = DataOut;
                cnt_d   = cnt_q + 8'd1;
                valid_d = 1'b1;
                last_d  = (cnt_q + 8'd1 == len_q);
            end
            PUSH: if (ByteReady) begin
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (last_q) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    code_d  = {sc_q[4], 2'b00};
                end else begin
                    state_d   = RD_BUF;
                    re_d      = 1'b1;
                    address_d = ADDR_BUFF;
                end
            end
            DROP, DONE: begin
                state_d = GAP;
                gap_d   = GAP_LOAD;
            end
            GAP: begin
                if (gap_q == 8'd0) state_d = IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) && (state_d != GAP);
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= IDLE;
            sc_q      <= 8'h00;
            len_q     <= 8'h00;
            cnt_q     <= 8'h00;
            gap_q     <= 8'h00;
            address_q <= 3'd0;
            we_q      <= 1'b0;
            re_q      <= 1'b0;
            data_in_q <= 8'h00;
            byte_q    <= 8'h00;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            done_q    <= 1'b0;
            drop_q    <= 1'b0;
            code_q    <= 3'd0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sc_q      <= sc_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            address_q <= address_d;
            we_q      <= we_d;
            re_q      <= re_d;
            data_in_q <= data_in_d;
            byte_q    <= byte_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            done_q    <= done_d;
            drop_q    <= drop_d;
            code_q    <= code_d;
            busy_q    <= busy_d;
        end
    end

    assign Address     = address_q;
    assign WriteEnable = we_q;
    assign ReadEnable  = re_q;
    assign DataIn      = data_in_q;
    assign Byte        = byte_q;
    assign ByteValid   = valid_q;
    assign ByteLast    = last_q;
    assign FrameDone   = done_q;
    assign FrameDrop   = drop_q;
    assign DropCode    = code_q;
    assign Busy        = busy_q;

endmodule

// File: tb/tb_hdlc_rx_drain.sv
// Directed bench for hdlc_rx_drain: a behavioural HDLC register port answers reads,
// and a monitor logs strobes and accepted stream bytes for the scenario tasks.
module tb_hdlc_rx_drain;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Enable = 1'b0;
    logic [2:0] Address;
    logic       WriteEnable, ReadEnable;
    logic [7:0] DataIn;
    logic [7:0] DataOut = 8'h00;
    logic [7:0] Byte;
    logic       ByteValid, ByteLast;
    logic       ByteReady = 1'b1;
    logic       FrameDone, FrameDrop;
    logic [2:0] DropCode;
    logic       Busy;

    hdlc_rx_drain #(.POLL_GAP(4), .MAX_LEN(126)) dut (
        .Clk(Clk), .Rst(Rst), .Enable(Enable), .Address(Address),
        .WriteEnable(WriteEnable), .ReadEnable(ReadEnable), .DataIn(DataIn),
        .DataOut(DataOut), .Byte(Byte), .ByteValid(ByteValid), .ByteLast(ByteLast),
        .ByteReady(ByteReady), .FrameDone(FrameDone), .FrameDrop(FrameDrop),
        .DropCode(DropCode), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    // Core register contents, set by the scenario tasks.
    logic [7:0] rx_sc_m = 8'h00;
    logic [7:0] rx_len_m = 8'h00;
    logic [7:0] buf_m [0:7];
    int         rd3_base = 0;

    // Monitor state, written only by the monitor.
    int         cyc = 0, rd2 = 0, rd3 = 0, rd4 = 0, wr = 0, both = 0;
    int         rd2_prev_cyc = 0, rd2_last_cyc = 0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    int         acc = 0, acc_cyc = 0, done_cnt = 0, done_cyc = 0, drop_cnt = 0;
    logic [7:0] acc_byte [0:255];
    logic       acc_last [0:255];
    int         strobes = 0;
    logic [2:0] strobe_addr = 3'd0;
    logic       strobe_rd = 1'b0;

    always @(posedge Clk) begin
        int idx;
        cyc++;
        if (ReadEnable && WriteEnable) both++;
        if (ReadEnable || WriteEnable) begin
            strobes++;
            strobe_addr = Address;
            strobe_rd = ReadEnable;
        end
        if (ReadEnable) begin
            case (Address)
                3'd2: begin
                    rd2++;
                    rd2_prev_cyc = rd2_last_cyc;
                    rd2_last_cyc = cyc;
                    DataOut <= rx_sc_m;
                end
                3'd3: begin
                    idx = (rd3 - rd3_base) & 7;
                    rd3++;
                    DataOut <= buf_m[idx];
                end
                3'd4: begin
                    rd4++;
                    DataOut <= rx_len_m;
                end
                default: DataOut <= 8'h00;
            endcase
        end
        if (WriteEnable) begin
            wr++;
            wr_addr = Address;
            wr_data = DataIn;
        end
        if (Rst && ByteValid && ByteReady) begin
            acc_byte[acc & 255] = Byte;
            acc_last[acc & 255] = ByteLast;
            acc++;
            acc_cyc = cyc;
        end
        if (FrameDone) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (FrameDrop) drop_cnt++;
    end

    task automatic setup_frame(input logic [7:0] sc, input logic [7:0] len,
                               input logic [7:0] b0, input logic [7:0] b1,
                               input logic [7:0] b2, input logic [7:0] b3);
        rx_sc_m = sc;
        rx_len_m = len;
        buf_m[0] = b0; buf_m[1] = b1; buf_m[2] = b2; buf_m[3] = b3;
        rd3_base = rd3;
    endtask

    task automatic start_frame();
        int n = 0;
        @(negedge Clk);
        Enable = 1'b1;
        while (!Busy && n < 20) begin
            @(negedge Clk);
            n++;
        end
        Enable = 1'b0;
    endtask

    task automatic wait_end(input string name);
        int e0 = done_cnt + drop_cnt;
        int n = 0;
        while (done_cnt + drop_cnt == e0 && n < 300) begin
            @(negedge Clk);
            n++;
        end
        checks++;
        if (done_cnt + drop_cnt == e0) begin
            failures++;
            $display("FAIL %s_timeout: no FrameDone/FrameDrop within 300 cycles", name);
        end
        repeat (10) @(negedge Clk);
    endtask

    task automatic test_reset();
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        checks++;
        if ({Address, WriteEnable, ReadEnable, DataIn, Byte, ByteValid, ByteLast,
             FrameDone, FrameDrop, DropCode, Busy} !== 28'd0) begin
            failures++;
            $display("FAIL reset_outputs: got addr=%0h we=%b re=%b din=%h byte=%h v=%b l=%b done=%b drop=%b code=%b busy=%b, expected all 0",
                     Address, WriteEnable, ReadEnable, DataIn, Byte, ByteValid, ByteLast,
                     FrameDone, FrameDrop, DropCode, Busy);
        end
        Rst = 1'b1;
        repeat (3) @(negedge Clk);
        checks++;
        if (ReadEnable !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL idle_without_enable: re=%b busy=%b, expected 0 0", ReadEnable, Busy);
        end
    endtask

    task automatic test_poll_period();
        int r0 = rd2, r4 = rd4, n = 0;
        setup_frame(8'h00, 8'd0, 8'h00, 8'h00, 8'h00, 8'h00);
        @(negedge Clk);
        Enable = 1'b1;
        while (rd2 < r0 + 3 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        Enable = 1'b0;
        checks++;
        if (rd2_last_cyc - rd2_prev_cyc != 7) begin
            failures++;
            $display("FAIL poll_period: got %0d cycles, expected 7", rd2_last_cyc - rd2_prev_cyc);
        end
        checks++;
        if (rd4 != r4) begin
            failures++;
            $display("FAIL poll_no_len_read: got %0d len reads, expected 0", rd4 - r4);
        end
        repeat (10) @(negedge Clk);
    endtask

    task automatic test_frame_len3();
        int a0 = acc, r3 = rd3, gap = 0;
        logic [7:0] exp_b [0:2];
        exp_b[0] = 8'hA1; exp_b[1] = 8'hB2; exp_b[2] = 8'hC3;
        setup_frame(8'h01, 8'd3, 8'hA1, 8'hB2, 8'hC3, 8'h00);
        ByteReady = 1'b1;
        start_frame();
        wait_end("len3");
        checks++;
        if (acc - a0 != 3) begin
            failures++;
            $display("FAIL len3_count: got %0d bytes, expected 3", acc - a0);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (acc_byte[(a0 + i) & 255] !== exp_b[i] || acc_last[(a0 + i) & 255] !== (i == 2)) begin
                failures++;
                $display("FAIL len3_byte%0d: got %h last=%b, expected %h last=%b",
                         i, acc_byte[(a0 + i) & 255], acc_last[(a0 + i) & 255], exp_b[i], i == 2);
            end
        end
        gap = done_cyc - acc_cyc;
        checks++;
        if (gap != 1) begin
            failures++;
            $display("FAIL len3_done_delay: got %0d, expected 1", gap);
        end
        checks++;
        if (rd3 - r3 != 3 || DropCode !== 3'b000) begin
            failures++;
            $display("FAIL len3_reads_code: got %0d buf reads code=%b, expected 3 and 000", rd3 - r3, DropCode);
        end
    endtask

    task automatic test_throughput();
        int a0 = acc, c1 = 0, c2 = 0, n = 0;
        setup_frame(8'h01, 8'd3, 8'h10, 8'h20, 8'h30, 8'h00);
        ByteReady = 1'b1;
        start_frame();
        while (acc < a0 + 2 && n < 100) begin
            @(negedge Clk);
            n++;
            if (acc == a0 + 1 && c1 == 0) c1 = acc_cyc;
        end
        c2 = acc_cyc;
        checks++;
        if (c2 - c1 != 3) begin
            failures++;
            $display("FAIL throughput: got %0d cycles per byte, expected 3", c2 - c1);
        end
        wait_end("throughput");
    endtask

    task automatic test_stall();
        int a0 = acc, r3 = rd3, d0 = done_cnt, stall = 0, rs = 0, n = 0;
        setup_frame(8'h01, 8'd3, 8'hA1, 8'hB2, 8'hC3, 8'h00);
        ByteReady = 1'b1;
        start_frame();
        while (done_cnt == d0 && n < 200) begin
            @(negedge Clk);
            n++;
            if (ByteValid && Byte == 8'hB2 && stall < 5) begin
                if (stall == 0) rs = rd3;
                ByteReady = 1'b0;
                stall++;
                checks++;
                if (Byte !== 8'hB2 || ByteLast !== 1'b0 || rd3 != rs) begin
                    failures++;
                    $display("FAIL stall_hold: byte=%h last=%b extra_reads=%0d, expected B2 0 0",
                             Byte, ByteLast, rd3 - rs);
                end
            end else begin
                ByteReady = 1'b1;
            end
        end
        ByteReady = 1'b1;
        checks++;
        if (stall != 5) begin
            failures++;
            $display("FAIL stall_seen: got %0d stalled cycles, expected 5", stall);
        end
        checks++;
        if (acc - a0 != 3 || acc_byte[a0 & 255] !== 8'hA1 || acc_byte[(a0 + 1) & 255] !== 8'hB2 ||
            acc_byte[(a0 + 2) & 255] !== 8'hC3 || rd3 - r3 != 3) begin
            failures++;
            $display("FAIL stall_order: got n=%0d %h %h %h reads=%0d, expected 3 A1 B2 C3 3",
                     acc - a0, acc_byte[a0 & 255], acc_byte[(a0 + 1) & 255],
                     acc_byte[(a0 + 2) & 255], rd3 - r3);
        end
        repeat (10) @(negedge Clk);
    endtask

    task automatic test_abort();
        int a0 = acc, w0 = wr, dr0 = drop_cnt, r4 = rd4;
        setup_frame(8'h08, 8'd3, 8'h01, 8'h02, 8'h03, 8'h00);
        start_frame();
        wait_end("abort");
        checks++;
        if (wr - w0 != 1 || wr_addr !== 3'd2 || wr_data !== 8'h02) begin
            failures++;
            $display("FAIL abort_write: got %0d writes addr=%0h data=%h, expected 1 2 02", wr - w0, wr_addr, wr_data);
        end
        checks++;
        if (drop_cnt - dr0 != 1 || DropCode !== 3'b010) begin
            failures++;
            $display("FAIL abort_drop: got %0d drops code=%b, expected 1 010", drop_cnt - dr0, DropCode);
        end
        checks++;
        if (acc != a0 || rd4 != r4) begin
            failures++;
            $display("FAIL abort_no_stream: got %0d bytes %0d len reads, expected 0 0", acc - a0, rd4 - r4);
        end
    endtask

    task automatic test_len_drop(input logic [7:0] len);
        int r3 = rd3, dr0 = drop_cnt, a0 = acc;
        setup_frame(8'h01, len, 8'h55, 8'h66, 8'h77, 8'h00);
        start_frame();
        wait_end("len_drop");
        checks++;
        if (DropCode !== 3'b001 || drop_cnt - dr0 != 1 || wr_data !== 8'h02) begin
            failures++;
            $display("FAIL len_drop_%0d: got code=%b drops=%0d wdata=%h, expected 001 1 02",
                     len, DropCode, drop_cnt - dr0, wr_data);
        end
        checks++;
        if (rd3 != r3 || acc != a0) begin
            failures++;
            $display("FAIL len_drop_%0d_nobuf: got %0d buf reads %0d bytes, expected 0 0", len, rd3 - r3, acc - a0);
        end
    endtask

    task automatic test_overflow();
        int a0 = acc, d0 = done_cnt, dr0 = drop_cnt;
        setup_frame(8'h11, 8'd2, 8'h3C, 8'h4D, 8'h00, 8'h00);
        start_frame();
        wait_end("overflow");
        checks++;
        if (acc - a0 != 2 || acc_byte[a0 & 255] !== 8'h3C || acc_byte[(a0 + 1) & 255] !== 8'h4D ||
            acc_last[(a0 + 1) & 255] !== 1'b1) begin
            failures++;
            $display("FAIL overflow_stream: got n=%0d %h %h, expected 2 3C 4D(last)",
                     acc - a0, acc_byte[a0 & 255], acc_byte[(a0 + 1) & 255]);
        end
        checks++;
        if (done_cnt - d0 != 1 || drop_cnt != dr0 || DropCode !== 3'b100) begin
            failures++;
            $display("FAIL overflow_code: got done=%0d drop=%0d code=%b, expected 1 0 100",
                     done_cnt - d0, drop_cnt - dr0, DropCode);
        end
    endtask

    task automatic test_reset_mid();
        int a0 = acc, n = 0, s0, d0, dr0;
        setup_frame(8'h01, 8'd4, 8'h91, 8'h92, 8'h93, 8'h94);
        start_frame();
        while (acc < a0 + 2 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        Rst = 1'b0;
        #1;
        checks++;
        if ({Address, ReadEnable, WriteEnable, Byte, ByteValid, ByteLast, Busy, DropCode} !== 20'd0) begin
            failures++;
            $display("FAIL reset_mid_outputs: addr=%0h re=%b we=%b byte=%h v=%b l=%b busy=%b code=%b, expected all 0",
                     Address, ReadEnable, WriteEnable, Byte, ByteValid, ByteLast, Busy, DropCode);
        end
        d0 = done_cnt;
        dr0 = drop_cnt;
        Enable = 1'b1;
        @(negedge Clk);
        s0 = strobes;
        Rst = 1'b1;
        n = 0;
        while (strobes == s0 && n < 20) begin
            @(negedge Clk);
            n++;
        end
        Enable = 1'b0;
        checks++;
        if (strobes == s0 || strobe_addr !== 3'd2 || strobe_rd !== 1'b1 || done_cnt != d0 || drop_cnt != dr0) begin
            failures++;
            $display("FAIL reset_mid_restart: strobes=%0d addr=%0h read=%b done=%0d drop=%0d, expected read of 2 and no pulses",
                     strobes - s0, strobe_addr, strobe_rd, done_cnt - d0, drop_cnt - dr0);
        end
        wait_end("reset_mid");
    endtask

    task automatic test_exclusive();
        checks++;
        if (both != 0) begin
            failures++;
            $display("FAIL strobe_exclusive: got %0d cycles with both strobes, expected 0", both);
        end
    endtask

    initial begin
        test_reset();
        test_poll_period();
        test_frame_len3();
        test_throughput();
        test_stall();
        test_abort();
        test_len_drop(8'd0);
        test_len_drop(8'd200);
        test_len_drop(8'd127);
        test_overflow();
        test_reset_mid();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
